im_loader: RTL and testbench
============================

IM_LOADER -- requirements
Module: im_loader

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high; forces reset state immediately, independent of clk.
REQ-003 SHALL have port: start  input  1  begin-load request, sampled on clk edge.
REQ-004 SHALL have port: word_count  input  11  number of 32-bit words to load, legal 1..1024, sampled with start.
REQ-005 SHALL have port: byte_valid  input  1  source has a byte on byte_data.
REQ-006 SHALL have port: byte_data  input  8  program byte stream.
REQ-007 SHALL have port: byte_ready  output  1  loader accepts a byte; transfer occurs when byte_valid and byte_ready are both 1 at a clk edge.
REQ-008 SHALL have port: im_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 SHALL have port: im_addr  output  10  word index into the 1024-word instruction memory (byte address bits 11:2).
REQ-010 SHALL have port: im_wdata  output  32  assembled instruction word.
REQ-011 SHALL have port: busy  output  1  load in progress.
REQ-012 SHALL have port: done  output  1  load complete, sticky.
REQ-013 SHALL have port: cpu_hold  output  1  1 = fetch stage held; the core drives PC_en from its inverse.
REQ-014 SHALL have port: err  output  1  illegal start seen, sticky until next legal start or reset.

Function
REQ-015 SHALL implement four states: IDLE, RECV, WRITE, DONE.
REQ-016 IDLE: byte_ready=0, busy=0, cpu_hold=1; start with word_count in 1..1024 -> RECV, im_addr=0, byte index=0, err cleared.
REQ-017 IDLE/DONE: start with word_count=0 or >1024 -> err=1, state and done unchanged.
REQ-018 RECV: byte_ready=1, busy=1; byte_ready SHALL depend on state only, never combinationally on byte_valid.
REQ-019 RECV: bytes assembled big-endian -- 1st accepted byte -> im_wdata[31:24], 2nd -> [23:16], 3rd -> [15:8], 4th -> [7:0]; cycles with byte_valid=0 stall without loss.
REQ-020 RECV: on the 4th accepted byte -> WRITE next cycle; 2-bit byte index wraps to 0.
REQ-021 WRITE: im_we=1 for exactly one cycle with stable im_addr/im_wdata; byte_ready=0 (4 bytes per 5 cycles max throughput).
REQ-022 WRITE: if words written == word_count latched -> DONE; else im_addr+1 -> RECV.
REQ-023 im_addr SHALL never exceed 1023; word_count=1024 ends with final write at im_addr=1023, no wrap.
REQ-024 DONE: done=1, cpu_hold=0, busy=0, byte_ready=0, im_we=0; bytes offered are not accepted.
REQ-025 DONE: legal start -> RECV, done=0, cpu_hold=1 same edge, im_addr=0 (reload).
REQ-026 start during RECV or WRITE SHALL be ignored (no restart, no err).
REQ-027 word_count SHALL be latched at the accepting start; later changes have no effect on the current load.
REQ-028 im_wdata SHALL hold its last value outside WRITE; memory correctness relies only on im_we.

Reset
REQ-029 reset=1 SHALL immediately force IDLE, byte_ready=0, im_we=0, im_addr=0, im_wdata=0, busy=0, done=0, err=0, cpu_hold=1.
REQ-030 reset mid-load SHALL abort with no further im_we; partial word discarded; a subsequent start reloads from im_addr=0.
REQ-031 reset deassertion SHALL leave the block in IDLE awaiting start; no write occurs in the deassertion cycle.

Verification
REQ-032 Single word: start, word_count=1, bytes 3C,08,00,10 back-to-back -> one im_we, im_addr=0, im_wdata=3C080010, then done=1, cpu_hold=0.
REQ-033 Stalled stream: word_count=2, byte_valid toggled 0/1 randomly -> writes 0 and 1 with correct words, no lost/duplicated byte, im_we exactly twice.
REQ-034 Full memory: word_count=1024, incrementing pattern -> 1024 writes, last at im_addr=3FF, done=1, no write to address 0 after the first.
REQ-035 Illegal start: word_count=0, then 1025 -> err=1, state IDLE, byte_ready=0; then legal start -> err=0, load proceeds.
REQ-036 Async reset mid-load: assert reset between 2nd and 3rd byte of word 5, off clock edge -> outputs at reset values before next edge, no im_we; reload from im_addr=0 succeeds.
REQ-037 Restart from DONE and start-while-busy: start pulsed during RECV ignored; start in DONE -> done=0, cpu_hold=1 same edge, reload writes from im_addr=0.

Source files
------------

// File: rtl/im_loader_if.sv
// Byte-stream handshake between a program source and the instruction loader.
// A byte moves when byte_valid and byte_ready are both high at a clock edge.
interface im_loader_if;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_ready;

    // Source side: offers bytes, observes the loader's ready.
    modport master (
        output byte_valid,
        output byte_data,
        input  byte_ready
    );

    // Loader side: consumes bytes when it is ready.
    modport slave (
        input  byte_valid,
        input  byte_data,
        output byte_ready
    );
endinterface

// File: rtl/im_loader.sv
// Instruction-memory loader: assembles a big-endian byte stream into 32-bit
// words, writes them to consecutive word addresses starting at 0, and holds
// the CPU fetch stage until the requested number of words has been written.
module im_loader (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [10:0] word_count,
    im_loader_if.slave  bs,
    output logic        im_we,
    output logic [9:0]  im_addr,
    output logic [31:0] im_wdata,
    output logic        busy,
    output logic        done,
    output logic        cpu_hold,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    state_t      state_q, state_d;
    logic [9:0]  addr_q, addr_d;
    logic [9:0]  last_q, last_d;     // address of the final word of this load
    logic [1:0]  bidx_q, bidx_d;
    logic [23:0] shift_q, shift_d;   // first three bytes of the word in flight
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;

    logic start_legal;
    logic accept;

    // A start is legal only for 1..1024 words.
    assign start_legal = start && (word_count != 11'd0) && (word_count <= 11'd1024);
    assign accept      = (state_q == RECV) && bs.byte_valid;

    // State and datapath registers; reset discards any partial word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            last_q  <= '0;
            bidx_q  <= '0;
            shift_q <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
            bidx_q  <= bidx_d;
            shift_q <= shift_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: accept starts when not loading, gather four bytes,
    // then spend one cycle writing the word.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        last_d  = last_q;
        bidx_d  = bidx_q;
        shift_d = shift_q;
        wdata_d = wdata_q;
        err_d   = err_q;

        case (state_q)
            IDLE, DONE: begin
                if (start_legal) begin
                    state_d = RECV;
                    addr_d  = '0;
                    bidx_d  = '0;
                    err_d   = 1'b0;
                    // 1024 wraps to 0 in ten bits, so minus one gives 3FF.
                    last_d  = word_count[9:0] - 10'd1;
                end else if (start) begin
                    err_d = 1'b1;
                end
            end
            RECV: begin
                if (accept) begin
                    shift_d = {shift_q[15:0], bs.byte_data};
                    bidx_d  = bidx_q + 2'd1;
                    if (bidx_q == 2'd3) begin
                        wdata_d = {shift_q, bs.byte_data};
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                if (addr_q == last_q) begin
                    state_d = DONE;
                end else begin
                    addr_d  = addr_q + 10'd1;
                    state_d = RECV;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs depend on state only, so byte_ready never follows byte_valid.
    assign bs.byte_ready = (state_q == RECV);
    assign im_we         = (state_q == WRITE);
    assign im_addr       = addr_q;
    assign im_wdata      = wdata_q;
    assign busy          = (state_q == RECV) || (state_q == WRITE);
    assign done          = (state_q == DONE);
    assign cpu_hold      = (state_q != DONE);
    assign err           = err_q;

endmodule

// File: tb/tb_im_loader.sv
// Testbench for im_loader: directed loads with a word-level reference model.
module tb_im_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [10:0] word_count;
    logic        im_we;
    logic [9:0]  im_addr;
    logic [31:0] im_wdata;
    logic        busy;
    logic        done;
    logic        cpu_hold;
    logic        err;

    im_loader_if bif();

    im_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .word_count (word_count),
        .bs         (bif.slave),
        .im_we      (im_we),
        .im_addr    (im_addr),
        .im_wdata   (im_wdata),
        .busy       (busy),
        .done       (done),
        .cpu_hold   (cpu_hold),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: expected writes in order, load phase, sticky error.
    logic [9:0]  exp_addr[$];
    logic [31:0] exp_data[$];
    int          mdl_phase = 0;   // 0 idle, 1 loading, 2 done
    logic        mdl_err   = 1'b0;

    logic [7:0]  tx_bytes[$];
    int          tx_idx = 0;

    int          we_cnt    = 0;
    logic [9:0]  last_addr = '0;
    logic [31:0] last_data = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, expv);
        end
    endtask

    // Per-cycle compare of the DUT against the model.
    always @(negedge clk) begin
        logic popped_last;
        popped_last = 1'b0;
        case (mdl_phase)
            0: chk("idle_status", {27'd0, busy, done, cpu_hold, bif.byte_ready, im_we}, 32'b00100);
            1: chk("load_status", {28'd0, busy, done, cpu_hold, bif.byte_ready}, {28'd0, 3'b101, ~im_we});
            default: chk("done_status", {27'd0, busy, done, cpu_hold, bif.byte_ready, im_we}, 32'b01000);
        endcase
        chk("err", {31'd0, err}, {31'd0, mdl_err});
        if (im_we) begin
            if (exp_addr.size() == 0) begin
                chk("unexpected_write", {22'd0, im_addr}, 32'hFFFF_FFFF);
            end else begin
                chk("wr_addr", {22'd0, im_addr}, {22'd0, exp_addr.pop_front()});
                chk("wr_data", im_wdata, exp_data.pop_front());
                popped_last = (exp_addr.size() == 0);
            end
            we_cnt++;
            last_addr = im_addr;
            last_data = im_wdata;
        end
        if (popped_last && mdl_phase == 1) mdl_phase = 2;
    end

    // Build a byte stream (seed + k) and the words it must produce.
    task automatic prepare(input int nw, input logic [7:0] seed);
        tx_bytes.delete();
        tx_idx = 0;
        for (int k = 0; k < 4 * nw; k++) tx_bytes.push_back(seed + 8'(k));
        for (int w = 0; w < nw; w++) begin
            exp_addr.push_back(10'(w));
            exp_data.push_back({tx_bytes[4*w], tx_bytes[4*w+1], tx_bytes[4*w+2], tx_bytes[4*w+3]});
        end
    endtask

    task automatic do_start(input logic [10:0] wc);
        @(negedge clk);
        bif.byte_valid = 1'b0;
        start = 1'b1;
        word_count = wc;
        @(posedge clk);
        #1;
        start = 1'b0;
        word_count = 11'd7;
        if (mdl_phase != 1) begin
            if (wc >= 11'd1 && wc <= 11'd1024) begin
                mdl_phase = 1;
                mdl_err   = 1'b0;
            end else begin
                mdl_err = 1'b1;
            end
        end
    endtask

    // Offer n bytes, stalling stall_pct percent of cycles; returns just after
    // the edge that accepts the last one.
    task automatic send_bytes(input int n, input int stall_pct);
        int sent;
        int guard;
        logic v;
        logic rdy;
        sent = 0;
        guard = 0;
        while (sent < n && guard < 20000) begin
            @(negedge clk);
            v = ($urandom_range(0, 99) >= stall_pct);
            bif.byte_valid = v;
            bif.byte_data  = tx_bytes[tx_idx];
            rdy = bif.byte_ready;
            @(posedge clk);
            if (v && rdy) begin
                tx_idx++;
                sent++;
            end
            guard++;
        end
        if (sent < n) chk("send_timeout", sent, n);
    endtask

    task automatic wait_done();
        int g;
        g = 0;
        while (mdl_phase != 2 && g < 2000) begin
            @(negedge clk);
            g++;
        end
        chk("load_completed", mdl_phase, 2);
        @(negedge clk);
        #1;
        chk("done_flag", {31'd0, done}, 32'd1);
    endtask

    initial begin
        int base;
        reset = 1'b1;
        start = 1'b0;
        word_count = '0;
        bif.byte_valid = 1'b0;
        bif.byte_data  = '0;
        #1;
        chk("rst_addr", {22'd0, im_addr}, 32'd0);
        chk("rst_wdata", im_wdata, 32'd0);
        chk("rst_flags", {25'd0, busy, done, err, cpu_hold, bif.byte_ready, im_we, 1'b0}, 32'b0001000);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Illegal starts from IDLE
        do_start(11'd0);
        chk("ill0_err", {31'd0, err}, 32'd1);
        chk("ill0_ready", {31'd0, bif.byte_ready}, 32'd0);
        do_start(11'd1025);
        chk("ill1025_err", {31'd0, err}, 32'd1);
        chk("ill1025_busy", {31'd0, busy}, 32'd0);

        // Single word 3C 08 00 10
        tx_bytes.delete();
        tx_idx = 0;
        tx_bytes.push_back(8'h3C);
        tx_bytes.push_back(8'h08);
        tx_bytes.push_back(8'h00);
        tx_bytes.push_back(8'h10);
        exp_addr.push_back(10'd0);
        exp_data.push_back(32'h3C08_0010);
        do_start(11'd1);
        chk("legal_clears_err", {31'd0, err}, 32'd0);
        send_bytes(4, 0);
        wait_done();
        chk("single_we_cnt", we_cnt, 1);
        chk("single_addr", {22'd0, last_addr}, 32'd0);
        chk("single_data", last_data, 32'h3C08_0010);
        chk("single_hold_released", {31'd0, cpu_hold}, 32'd0);
        chk("wdata_held", im_wdata, 32'h3C08_0010);

        // Illegal start in DONE keeps done
        do_start(11'd0);
        chk("done_ill_err", {31'd0, err}, 32'd1);
        chk("done_ill_done", {31'd0, done}, 32'd1);

        // Stalled stream, two words
        prepare(2, 8'hA0);
        do_start(11'd2);
        send_bytes(8, 50);
        wait_done();
        chk("stall_we_cnt", we_cnt, 3);
        chk("stall_word1", last_data, 32'hA4A5_A6A7);

        // Restart from DONE with start pulses in RECV and WRITE
        prepare(3, 8'h10);
        do_start(11'd3);
        chk("restart_done", {31'd0, done}, 32'd0);
        chk("restart_hold", {31'd0, cpu_hold}, 32'd1);
        send_bytes(2, 0);
        do_start(11'd0);
        send_bytes(2, 0);
        do_start(11'd5);
        send_bytes(8, 25);
        wait_done();
        chk("restart_we_cnt", we_cnt, 6);
        chk("restart_last", last_data, 32'h181A_1B1C - 32'h0001_0101);

        // Full memory
        base = we_cnt;
        prepare(1024, 8'h00);
        do_start(11'd1024);
        send_bytes(4096, 0);
        wait_done();
        chk("full_we_cnt", we_cnt - base, 1024);
        chk("full_last_addr", {22'd0, last_addr}, 32'h3FF);
        chk("full_last_data", last_data, 32'hFCFD_FEFF);

        // Async reset between 2nd and 3rd byte of word 5
        base = we_cnt;
        prepare(8, 8'h55);
        do_start(11'd8);
        send_bytes(18, 0);
        chk("pre_rst_we_cnt", we_cnt - base, 4);
        #2;
        reset = 1'b1;
        exp_addr.delete();
        exp_data.delete();
        mdl_phase = 0;
        mdl_err = 1'b0;
        #1;
        chk("async_rst_addr", {22'd0, im_addr}, 32'd0);
        chk("async_rst_wdata", im_wdata, 32'd0);
        chk("async_rst_flags", {26'd0, busy, done, err, cpu_hold, bif.byte_ready, im_we}, 32'b000100);
        bif.byte_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
        base = we_cnt;
        prepare(2, 8'hC0);
        do_start(11'd2);
        send_bytes(8, 0);
        wait_done();
        chk("reload_we_cnt", we_cnt - base, 2);
        chk("reload_last_addr", {22'd0, last_addr}, 32'd1);
        chk("reload_last_data", last_data, 32'hC4C5_C6C7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
